// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse sequencer: state encoding, counter
// width, minimum period and the power-up parameter defaults.
package pulse_pkg;

  localparam int CW      = 32;
  localparam int PER_MIN = 16;

  typedef enum logic [2:0] {
    NUT  = 3'd0,
    NGAP = 3'd1,
    P1   = 3'd2,
    GAP1 = 3'd3,
    P2   = 3'd4,
    GAP2 = 3'd5,
    HOLD = 3'd6,
    TAIL = 3'd7
  } state_t;

  // Power-up values, identical to the UART parameter block's reset contents.
  localparam logic [31:0] DEF_PER = 32'd2010;
  localparam logic [31:0] DEF_P1  = 32'd20;
  localparam logic [31:0] DEF_DEL = 32'd200;
  localparam logic [31:0] DEF_P2  = 32'd40;
  localparam logic [7:0]  DEF_CP  = 8'd0;
  localparam logic [7:0]  DEF_PBL = 8'd8;

  function automatic logic is_pulse(input state_t s);
    return (s == NUT) || (s == P1) || (s == P2);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; done is high while the count is zero.
// Used both as the period counter and as the per-state phase counter.
module phase_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Period-locked RF gate / receiver blanking / scope sync generator.
// Optional nutation pre-pulse is built when NUTATION_EN is defined.
module pulse_sequencer #(
  parameter int CW      = pulse_pkg::CW,
  parameter int PER_MIN = pulse_pkg::PER_MIN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] per,
  input  logic [CW-1:0] p1wid,
  input  logic [CW-1:0] del,
  input  logic [CW-1:0] p2wid,
  input  logic [7:0]    cp,
  input  logic          pu,
  input  logic          bl,
  input  logic [7:0]    p_bl,
`ifdef NUTATION_EN
  input  logic [CW-1:0] nut_w,
  input  logic [CW-1:0] nut_d,
`endif
  output logic          sync,
  output logic          pulse,
  output logic          block,
  output logic          busy
);
  import pulse_pkg::*;

  state_t        state, state_n;
  logic          pc_zero, ph_done, ph_load, zero_q;
  logic [CW:0]   ph_len;
  logic [7:0]    p2_left;

  logic [CW-1:0] per_s, p1_s, del_s, p2_s;
  logic [7:0]    cp_s, pbl_s;
  logic          pu_s, bl_s;
  logic [CW-1:0] per_clamp, per_c, p1_c;
  logic [7:0]    cp_c;

  // Values needed in the wrap cycle itself come straight from the inputs,
  // since the shadows only update on that same edge.
  assign per_clamp = (per < CW'(PER_MIN)) ? CW'(PER_MIN) : per;
  assign per_c     = pc_zero ? per_clamp : per_s;
  assign p1_c      = pc_zero ? p1wid     : p1_s;
  assign cp_c      = pc_zero ? cp        : cp_s;

`ifdef NUTATION_EN
  logic [CW-1:0] nw_s, nd_s, nw_c;
  assign nw_c = pc_zero ? nut_w : nw_s;
`endif

  function automatic logic [CW:0] len_m1(input logic [CW:0] len);
    return (len == '0) ? '0 : len - (CW+1)'(1);
  endfunction

  phase_timer #(.W(CW)) u_period (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_zero),
    .load_val (per_c - CW'(1)),
    .done     (pc_zero)
  );

  phase_timer #(.W(CW+1)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (len_m1(ph_len)),
    .done     (ph_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_s <= CW'(DEF_PER);
      p1_s  <= CW'(DEF_P1);
      del_s <= CW'(DEF_DEL);
      p2_s  <= CW'(DEF_P2);
      cp_s  <= DEF_CP;
      pbl_s <= DEF_PBL;
      pu_s  <= 1'b0;
      bl_s  <= 1'b0;
`ifdef NUTATION_EN
      nw_s  <= '0;
      nd_s  <= '0;
`endif
    end else if (pc_zero) begin
      per_s <= per_clamp;
      p1_s  <= p1wid;
      del_s <= del;
      p2_s  <= p2wid;
      cp_s  <= cp;
      pbl_s <= p_bl;
      pu_s  <= pu;
      bl_s  <= bl;
`ifdef NUTATION_EN
      nw_s  <= nut_w;
      nd_s  <= nut_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TAIL;
      zero_q  <= 1'b0;
      p2_left <= '0;
    end else begin
      state <= state_n;
      if (ph_load) zero_q <= (ph_len == '0);
      if (pc_zero)
        p2_left <= cp_c;
      else if (ph_done && state == P2 && p2_left != 8'd0)
        p2_left <= p2_left - 8'd1;
    end
  end

  // The wrap always wins: an unfinished sequence is abandoned and restarted.
  always_comb begin
    state_n = state;
    ph_load = 1'b0;
    ph_len  = '0;
    if (pc_zero) begin
      ph_load = 1'b1;
      state_n = P1;
      ph_len  = {1'b0, p1_c};
`ifdef NUTATION_EN
      if (nw_c != '0) begin
        state_n = NUT;
        ph_len  = {1'b0, nw_c};
      end
`endif
    end else if (ph_done) begin
      ph_load = 1'b1;
      case (state)
`ifdef NUTATION_EN
        NUT: begin
          state_n = NGAP;
          ph_len  = {1'b0, nd_s};
        end
        NGAP: begin
          state_n = P1;
          ph_len  = {1'b0, p1_c};
        end
`endif
        P1: begin
          if (cp_s == 8'd0) begin
            state_n = HOLD;
            ph_len  = {{(CW-7){1'b0}}, pbl_s};
          end else begin
            state_n = GAP1;
            ph_len  = {1'b0, del_s};
          end
        end
        GAP1, GAP2: begin
          state_n = P2;
          ph_len  = {1'b0, p2_s};
        end
        P2: begin
          if (p2_left <= 8'd1) begin
            state_n = HOLD;
            ph_len  = {{(CW-7){1'b0}}, pbl_s};
          end else begin
            state_n = GAP2;
            ph_len  = {del_s, 1'b0};
          end
        end
        default: begin
          state_n = TAIL;
          ph_load = 1'b0;
        end
      endcase
    end
  end

  // Gating on the wrap cycle keeps an overrunning pulse from crossing into
  // the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 1'b0;
      pulse <= 1'b0;
      block <= 1'b0;
      busy  <= 1'b0;
    end else begin
      sync  <= pc_zero;
      pulse <= !pc_zero && pu_s && is_pulse(state) && !zero_q;
      block <= !pc_zero && bl_s && (state != TAIL);
      busy  <= (state != TAIL);
    end
  end

endmodule
